// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with elastic valid/ready stages.
// Stage k resolves bits [k*SW +: SW]; the unresolved operand bits travel down with the carry.
module pipelined_csel_adder #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int NBLK = WIDTH / (BLOCK * STAGES);
  localparam int SW   = NBLK * BLOCK;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q;
  logic              ovf_d;

  // Per-stage sources: stage 0 takes the port operands, stage k takes stage k-1.
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;
  logic [STAGES:0]   rdy;

  always_comb begin
    a_src[0] = in1_i;
    b_src[0] = sub_i ? ~in2_i : in2_i;
    s_src[0] = '0;
    c_src[0] = sub_i ^ cin_i;
    v_src[0] = in_valid_i;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = carry_q[k-1];
      v_src[k] = valid_q[k-1];
    end
  end

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    rdy[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    logic           c;
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    int             lo;
    c       = 1'b0;
    r0      = '0;
    r1      = '0;
    lo      = 0;
    carry_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_src[k];
      c      = c_src[k];
      for (int j = 0; j < NBLK; j++) begin
        lo = k * SW + j * BLOCK;
        r0 = {1'b0, a_src[k][lo +: BLOCK]} + {1'b0, b_src[k][lo +: BLOCK]};
        r1 = {1'b0, a_src[k][lo +: BLOCK]} + {1'b0, b_src[k][lo +: BLOCK]}
             + {{BLOCK{1'b0}}, 1'b1};
        s_d[k][lo +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
        c = c ? r1[BLOCK] : r0[BLOCK];
      end
      carry_d[k] = c;
    end
    ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
            (s_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) valid_q[k] <= v_src[k];
        if (rdy[k] && v_src[k]) begin
          a_q[k]     <= a_src[k];
          b_q[k]     <= b_src[k];
          s_q[k]     <= s_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
      if (rdy[LAST] && v_src[LAST]) ovf_q <= ovf_d;
    end
  end

  assign in_ready_o  = !rst && rdy[0];
  assign out_valid_o = valid_q[LAST];
  assign sum_o       = s_q[LAST];
  assign cout_o      = carry_q[LAST];
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: directed vector table, handshake sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_pipelined_csel_adder;
  localparam int W   = 16;
  localparam int ST  = 2;
  localparam int W2  = 32;
  localparam int ST2 = 4;

  typedef struct packed { logic [31:0] sum; logic cout; logic ovf; } res_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic ci; logic sb;
                   logic [31:0] s; logic co; logic ov; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] in1, in2, sum;
  logic          rst2, in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [W2-1:0] in1_2, in2_2, sum2;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  res_t mon_e;
  logic         hold_chk = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout, hold_ovf;

  pipelined_csel_adder #(.WIDTH(W), .BLOCK(4), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in1_i(in1), .in2_i(in2), .cin_i(cin), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum),
    .cout_o(cout), .ovf_o(ovf));

  pipelined_csel_adder #(.WIDTH(W2), .BLOCK(8), .STAGES(ST2)) dut32 (
    .clk(clk), .rst(rst2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in1_i(in1_2), .in2_i(in2_2), .cin_i(cin2), .sub_i(sub2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .sum_o(sum2),
    .cout_o(cout2), .ovf_o(ovf2));

  // Reference: unsigned compare for carry/borrow, signed range check for overflow.
  function automatic res_t model(input int w, input longint a, input longint b,
                                 input logic ci, input logic sb);
    res_t   r;
    longint lim, half, sa, sbv, sr, ur, cv;
    lim  = longint'(1) << w;
    half = lim / 2;
    cv   = ci ? 1 : 0;
    sa   = (a >= half) ? a - lim : a;
    sbv  = (b >= half) ? b - lim : b;
    if (sb) begin
      ur     = a - b - cv;
      sr     = sa - sbv - cv;
      r.cout = (a >= b + cv);
    end else begin
      ur     = a + b + cv;
      sr     = sa + sbv + cv;
      r.cout = (ur >= lim);
    end
    r.sum = 32'(ur & (lim - 1));
    r.ovf = (sr < -half) || (sr >= half);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
    in_valid = v;
    in1      = a[W-1:0];
    in2      = b[W-1:0];
    cin      = ci;
    sub      = sb;
  endtask

  task automatic drive2(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb);
    in_valid2 = v;
    in1_2     = a;
    in2_2     = b;
    cin2      = ci;
    sub2      = sb;
  endtask

  // Scoreboard on the 16-bit instance: order, values and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'(hold_sum));
        chk("hold_cout", 32'(cout), 32'(hold_cout));
        chk("hold_ovf", 32'(ovf), 32'(hold_ovf));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_out: got sum %h with no pending op", sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_sum", 32'(sum), mon_e.sum);
          chk("sb_cout", 32'(cout), 32'(mon_e.cout));
          chk("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(W, longint'(in1), longint'(in2), cin, sub));
      hold_chk  = out_valid && !out_ready;
      hold_sum  = sum;
      hold_cout = cout;
      hold_ovf  = ovf;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[9];
    vec_t         vt2[2];
    vec_t         bp[3];
    logic [31:0]  got[$];
    res_t         q2[$];
    res_t         e2;
    int           idx;

    vt[0] = '{32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0};
    vt[1] = '{32'hDA83, 32'h43AF, 1'b1, 1'b0, 32'h1E33, 1'b1, 1'b0};
    vt[2] = '{32'hAAAA, 32'h5555, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0};
    vt[3] = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vt[4] = '{32'h0000, 32'h0001, 1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b0};
    vt[5] = '{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
    vt[6] = '{32'h0005, 32'h0003, 1'b1, 1'b1, 32'h0001, 1'b1, 1'b0};
    vt[7] = '{32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0};
    vt[8] = '{32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1};
    vt2[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt2[1] = '{32'h12345678, 32'h12345679, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    bp[0] = '{32'h0001, 32'h0002, 1'b0, 1'b0, 32'h0003, 1'b0, 1'b0};
    bp[1] = '{32'h1000, 32'h0100, 1'b0, 1'b0, 32'h1100, 1'b0, 1'b0};
    bp[2] = '{32'h0010, 32'h0001, 1'b0, 1'b1, 32'h000F, 1'b1, 1'b0};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst2 = 1'b1;
    out_ready2 = 1'b1;
    drive2(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed table, back-to-back, exact latency of ST cycles.
    for (int i = 0; i < 9 + ST; i++) begin
      @(posedge clk); #1;
      if (i < 9) drive(1'b1, vt[i].a, vt[i].b, vt[i].ci, vt[i].sb);
      else       drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (i < 9) chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i >= ST) begin
        chk($sformatf("vec%0d_valid", i - ST), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_sum", i - ST), 32'(sum), vt[i-ST].s);
        chk($sformatf("vec%0d_cout", i - ST), 32'(cout), 32'(vt[i-ST].co));
        chk($sformatf("vec%0d_ovf", i - ST), 32'(ovf), 32'(vt[i-ST].ov));
      end else begin
        chk($sformatf("vec_lead%0d_valid", i), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: 4 stalled cycles while offering 3 operations.
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 3) drive(1'b1, bp[idx].a, bp[idx].b, bp[idx].ci, bp[idx].sb);
      else         drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (c >= 2) begin
        chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        chk($sformatf("bp_frozen_valid_c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp_frozen_sum_c%0d", c), 32'(sum), bp[0].s);
      end
      @(posedge clk); #1;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (idx < 3) drive(1'b1, bp[idx].a, bp[idx].b, bp[idx].ci, bp[idx].sb);
      else         drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got.push_back(32'(sum));
      @(posedge clk); #1;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_result_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk($sformatf("bp_order%0d", k), got[k], bp[k].s);

    // Asynchronous reset with two operations in flight.
    @(posedge clk); #1;
    drive(1'b1, 32'h7FFF, 32'h7FFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h0F0F, 32'h0101, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("prerst_valid", 32'(out_valid), 32'd1);
    chk("prerst_sum", 32'(sum), 32'h0000FFFE);
    chk("prerst_ovf", 32'(ovf), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("no_stale_c%0d", c), 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("rand_idle_valid", 32'(out_valid), 32'd0);

    // Wide variant: 32 bits, 8-bit blocks, 4 stages.
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int i = 0; i < 2 + ST2; i++) begin
      @(posedge clk); #1;
      if (i < 2) drive2(1'b1, vt2[i].a, vt2[i].b, vt2[i].ci, vt2[i].sb);
      else       drive2(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (i >= ST2) begin
        chk($sformatf("w32_vec%0d_valid", i - ST2), 32'(out_valid2), 32'd1);
        chk($sformatf("w32_vec%0d_sum", i - ST2), sum2, vt2[i-ST2].s);
        chk($sformatf("w32_vec%0d_cout", i - ST2), 32'(cout2), 32'(vt2[i-ST2].co));
        chk($sformatf("w32_vec%0d_ovf", i - ST2), 32'(ovf2), 32'(vt2[i-ST2].ov));
      end else begin
        chk($sformatf("w32_lead%0d_valid", i), 32'(out_valid2), 32'd0);
      end
    end
    q2.delete();
    @(posedge clk); #1;
    for (int c = 0; c < 120; c++) begin
      if (c >= 60 && q2.size() == 0) break;
      if (c < 60) drive2(($urandom_range(0, 3) != 0), $urandom, $urandom,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else        drive2(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      out_ready2 = (c >= 60) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w32_unexpected_out: got sum %h with no pending op", sum2);
        end else begin
          e2 = q2.pop_front();
          chk("w32_sum", sum2, e2.sum);
          chk("w32_cout", 32'(cout2), 32'(e2.cout));
          chk("w32_ovf", 32'(ovf2), 32'(e2.ovf));
        end
      end
      if (in_valid2 && in_ready2)
        q2.push_back(model(W2, longint'(in1_2), longint'(in2_2), cin2, sub2));
      @(posedge clk); #1;
    end
    chk("w32_drained", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
